// File: rtl/mux_skid_stage.sv
// Operand/writeback source selector feeding a valid/ready stage.
// A one-entry skid register keeps in_ready purely registered.
module mux_skid_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] din,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  out_sel_err
);

    // Handshake: a beat moves on a rising edge where valid & ready are both
    // high; the sender holds sel/din stable until that edge.

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;
    logic             drain;

    // Out-of-range select falls back to source 0 and raises the error flag.
    always_comb begin
        mux_data = din[WIDTH-1:0];
        mux_err  = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                mux_data = din[k*WIDTH +: WIDTH];
                mux_err  = 1'b0;
            end
        end
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            dout        <= '0;
            out_sel_err <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_err    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            // The skid beat is older than any new beat, so it goes first.
            if (skid_valid) begin
                out_valid   <= 1'b1;
                dout        <= skid_data;
                out_sel_err <= skid_err;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                dout        <= mux_data;
                out_sel_err <= mux_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= mux_data;
            skid_err   <= mux_err;
        end
    end

endmodule

// File: tb/tb_mux_skid_stage.sv
// Directed and randomised checks for mux_skid_stage: a 4-source instance
// for datapath/handshake behaviour and a 3-source instance for bad selects.
module tb_mux_skid_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstn;

    logic          in_valid, in_ready, flush, out_valid, out_ready, out_sel_err;
    logic [1:0]    sel;
    logic [4*W-1:0] din;
    logic [W-1:0]  dout;

    logic          in_valid3, in_ready3, flush3, out_valid3, out_ready3, out_sel_err3;
    logic [1:0]    sel3;
    logic [3*W-1:0] din3;
    logic [W-1:0]  dout3;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mux_skid_stage #(.WIDTH(W), .NSRC(4), .SELW(2)) u_dut4 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .din(din), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .out_sel_err(out_sel_err)
    );

    mux_skid_stage #(.WIDTH(W), .NSRC(3), .SELW(2)) u_dut3 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .din(din3), .flush(flush3), .out_valid(out_valid3),
        .out_ready(out_ready3), .dout(dout3), .out_sel_err(out_sel_err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 0; sel = 0; din = '0; flush = 0; out_ready = 1;
        in_valid3 = 0; sel3 = 0; din3 = '0; flush3 = 0; out_ready3 = 1;
        #3;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== '0 || out_sel_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b r=%b d=%h e=%b expected v=0 r=1 d=0 e=0",
                     out_valid, in_ready, dout, out_sel_err);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_passthrough();
        logic [1:0]   sels[4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic [W-1:0] exps[4] = '{32'h33, 32'h11, 32'h44, 32'h22};
        out_ready = 1;
        din = {32'h44, 32'h33, 32'h22, 32'h11};
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            sel = sels[i];
            step();
            tests_run++;
            if (out_valid !== 1'b1 || dout !== exps[i] || in_ready !== 1'b1 || out_sel_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL pass_beat%0d: got v=%b d=%h r=%b e=%b expected v=1 d=%h r=1 e=0",
                         i, out_valid, dout, in_ready, out_sel_err, exps[i]);
            end
        end
        in_valid = 0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || dout !== 32'h22) begin
            tests_failed++;
            $display("FAIL pass_idle_hold: got v=%b d=%h expected v=0 d=00000022", out_valid, dout);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] junk = 32'hdead0000;
        out_ready = 0;
        sel = 0;
        in_valid = 1;
        din = {junk | 3, junk | 2, junk | 1, 32'hA};
        step();
        tests_run++;
        if (out_valid !== 1'b1 || dout !== 32'hA || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_a_main: got v=%b d=%h r=%b expected v=1 d=0000000a r=1", out_valid, dout, in_ready);
        end
        din = {junk | 3, junk | 2, junk | 1, 32'hB};
        step();
        tests_run++;
        if (out_valid !== 1'b1 || dout !== 32'hA || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_b_skid: got v=%b d=%h r=%b expected v=1 d=0000000a r=0", out_valid, dout, in_ready);
        end
        din = {junk | 3, junk | 2, junk | 1, 32'hC};
        step();
        tests_run++;
        if (out_valid !== 1'b1 || dout !== 32'hA || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_c_held: got v=%b d=%h r=%b expected v=1 d=0000000a r=0", out_valid, dout, in_ready);
        end
        out_ready = 1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || dout !== 32'hB || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drain_b: got v=%b d=%h r=%b expected v=1 d=0000000b r=1", out_valid, dout, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || dout !== 32'hC) begin
            tests_failed++;
            $display("FAIL bp_drain_c: got v=%b d=%h expected v=1 d=0000000c", out_valid, dout);
        end
        in_valid = 0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || dout !== 32'hC) begin
            tests_failed++;
            $display("FAIL bp_empty: got v=%b d=%h expected v=0 d=0000000c", out_valid, dout);
        end
    endtask

    task automatic test_sel_err();
        din3 = {32'h77, 32'h66, 32'h55};
        in_valid3 = 1;
        sel3 = 2'd3;
        step();
        tests_run++;
        if (out_valid3 !== 1'b1 || dout3 !== 32'h55 || out_sel_err3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL selerr_bad: got v=%b d=%h e=%b expected v=1 d=00000055 e=1",
                     out_valid3, dout3, out_sel_err3);
        end
        sel3 = 2'd1;
        step();
        tests_run++;
        if (out_valid3 !== 1'b1 || dout3 !== 32'h66 || out_sel_err3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL selerr_next: got v=%b d=%h e=%b expected v=1 d=00000066 e=0",
                     out_valid3, dout3, out_sel_err3);
        end
        sel3 = 2'd2;
        step();
        tests_run++;
        if (dout3 !== 32'h77 || out_sel_err3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL selerr_top: got d=%h e=%b expected d=00000077 e=0", dout3, out_sel_err3);
        end
        in_valid3 = 0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 0;
        sel = 0;
        in_valid = 1;
        din = {32'h0, 32'h0, 32'h0, 32'h1};
        step();
        din = {32'h0, 32'h0, 32'h0, 32'h2};
        step();
        tests_run++;
        if (in_ready !== 1'b0 || dout !== 32'h1) begin
            tests_failed++;
            $display("FAIL flush_setup: got r=%b d=%h expected r=0 d=00000001", in_ready, dout);
        end
        din = {32'h0, 32'h0, 32'h0, 32'h3};
        flush = 1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 32'h1) begin
            tests_failed++;
            $display("FAIL flush_full: got v=%b r=%b d=%h expected v=0 r=1 d=00000001", out_valid, in_ready, dout);
        end
        din = {32'h0, 32'h0, 32'h0, 32'h9};
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_accept_drop: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        flush = 0;
        in_valid = 0;
        out_ready = 1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || dout !== 32'h1) begin
            tests_failed++;
            $display("FAIL flush_after: got v=%b d=%h expected v=0 d=00000001", out_valid, dout);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        sel = 0;
        in_valid = 1;
        din = {32'h0, 32'h0, 32'h0, 32'hD1};
        step();
        din = {32'h0, 32'h0, 32'h0, 32'hD2};
        step();
        in_valid = 0;
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== 32'hD1) begin
            tests_failed++;
            $display("FAIL arst_setup: got v=%b r=%b d=%h expected v=1 r=0 d=000000d1", out_valid, in_ready, dout);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== '0 || out_sel_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_immediate: got v=%b r=%b d=%h e=%b expected v=0 r=1 d=0 e=0",
                     out_valid, in_ready, dout, out_sel_err);
        end
        #2 rstn = 1'b1;
        out_ready = 1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_after: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic         acc;
        logic [W-1:0] exp_word;
        exp_q.delete();
        in_valid = 0;
        while (recv < 1000 && cyc < 20000) begin
            cyc++;
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid = 1;
                sel = 2'($urandom_range(0, 3));
                din = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            exp_word = din[sel*W +: W];
            if (!in_ready && !out_valid) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rand_ready_low: got r=0 v=0 expected r=1 while main empty (cycle %0d)", cyc);
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra_beat: got d=%h expected no beat", dout);
                end else begin
                    logic [W-1:0] want;
                    want = exp_q.pop_front();
                    if (dout !== want || out_sel_err !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL rand_beat%0d: got d=%h e=%b expected d=%h e=0", recv, dout, out_sel_err, want);
                    end
                end
                recv++;
            end
            step();
            if (acc) begin
                exp_q.push_back(exp_word);
                sent++;
                in_valid = 0;
            end
        end
        in_valid = 0;
        tests_run++;
        if (recv != 1000 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rand_total: got recv=%0d left=%0d expected recv=1000 left=0", recv, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_backpressure();
        test_sel_err();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
